// File: rtl/led_bank_pkg.sv
`default_nettype none
// led_bank_pkg: channel mode encoding, register map and reset values for led_bank.
// DUTY-related constants exist only when LED_BANK_PWM_EN is defined.
package led_bank_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_CH_BASE = 8'h04;

  localparam logic [1:0] OFF_PERIOD = 2'd0;
  localparam logic [1:0] OFF_MODE   = 2'd1;

  localparam logic [7:0] RST_CTRL   = 8'h01;
  localparam logic [7:0] RST_PERIOD = 8'h5D;
  localparam mode_e      RST_MODE   = MODE_BLINK;

`ifdef LED_BANK_PWM_EN
  localparam logic [1:0] OFF_DUTY = 2'd2;
  localparam logic [7:0] RST_DUTY = 8'h80;
`endif

  // Channel k occupies a 4-byte slot starting at ADDR_CH_BASE.
  function automatic logic [7:0] chan_addr(input int unsigned k, input logic [1:0] off);
    logic [7:0] base;
    base = ADDR_CH_BASE + 8'(k << 2);
    return base | {6'b000000, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_bank_chan.sv
`default_nettype none
// led_bank_chan: one LED channel -- blink counter, mode select and registered led drive.
// LED_BANK_PWM_EN adds the PWM compare inputs; without it MODE_PWM behaves as blink.
module led_bank_chan
  import led_bank_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic       i_tick,
  input  logic       i_clr,
  input  logic [7:0] i_period,
  input  mode_e      i_mode,
`ifdef LED_BANK_PWM_EN
  input  logic [7:0] i_pwm_cnt,
  input  logic [7:0] i_duty,
`endif
  output logic       o_led
);

  logic [7:0] r_cnt;
  logic       r_led;
  logic       w_blink;
  logic       w_pwm_hi;

  always_comb begin
    w_blink  = (i_mode == MODE_BLINK);
    w_pwm_hi = 1'b0;
`ifdef LED_BANK_PWM_EN
    w_pwm_hi = (i_mode == MODE_PWM) && (i_pwm_cnt < i_duty);
`else
    w_blink  = w_blink || (i_mode == MODE_PWM);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else if (!i_en || i_clr) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else if (w_blink) begin
      // Toggle on the tick after PERIOD increments: half-period is PERIOD+1 ticks.
      if (i_tick) begin
        if (r_cnt >= i_period) begin
          r_cnt <= '0;
          r_led <= ~r_led;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end else begin
      r_cnt <= '0;
      r_led <= (i_mode == MODE_ON) || w_pwm_hi;
    end
  end

  assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/led_bank.sv
`default_nettype none
// led_bank: register-mapped bank of NUM_CH LED channels with shared prescaler.
// Define LED_BANK_PWM_EN to add PWM mode, DUTY registers and the shared pwm counter.
module led_bank
  import led_bank_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [7:0]        addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [NUM_CH-1:0] led
);

  logic                   r_en;
  logic [PRESCALE_W-1:0]  r_presc;
  logic                   w_tick;
  logic [NUM_CH-1:0]      w_chan_led;
  logic [NUM_CH-1:0][7:0] w_ch_rdata;
  logic [7:0]             w_rdata;
  logic [7:0]             r_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en <= RST_CTRL[0];
    end else if (wr_en && (addr == ADDR_CTRL)) begin
      r_en <= data_in[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (!r_en) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESCALE_W'(1);
    end
  end

  assign w_tick = r_en && (&r_presc);

`ifdef LED_BANK_PWM_EN
  logic [7:0] r_pwm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm <= '0;
    end else if (!r_en) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 8'd1;
    end
  end
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [7:0] c_A_PER  = chan_addr(k, OFF_PERIOD);
    localparam logic [7:0] c_A_MODE = chan_addr(k, OFF_MODE);

    logic [7:0] r_period;
    mode_e      r_mode;
    logic       w_clr;

    // Reprogramming a channel restarts it from a dark, zero-count state.
    assign w_clr = wr_en && ((addr == c_A_PER) || (addr == c_A_MODE));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_period <= RST_PERIOD;
        r_mode   <= RST_MODE;
      end else if (wr_en) begin
        if (addr == c_A_PER)  r_period <= data_in;
        if (addr == c_A_MODE) r_mode   <= mode_e'(data_in[1:0]);
      end
    end

`ifdef LED_BANK_PWM_EN
    localparam logic [7:0] c_A_DUTY = chan_addr(k, OFF_DUTY);
    logic [7:0] r_duty;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_duty <= RST_DUTY;
      end else if (wr_en && (addr == c_A_DUTY)) begin
        r_duty <= data_in;
      end
    end

    assign w_ch_rdata[k] = (addr == c_A_PER)  ? r_period :
                           (addr == c_A_MODE) ? {6'b000000, r_mode} :
                           (addr == c_A_DUTY) ? r_duty : 8'h00;
`else
    assign w_ch_rdata[k] = (addr == c_A_PER)  ? r_period :
                           (addr == c_A_MODE) ? {6'b000000, r_mode} : 8'h00;
`endif

    led_bank_chan u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_en      (r_en),
      .i_tick    (w_tick),
      .i_clr     (w_clr),
      .i_period  (r_period),
      .i_mode    (r_mode),
`ifdef LED_BANK_PWM_EN
      .i_pwm_cnt (r_pwm),
      .i_duty    (r_duty),
`endif
      .o_led     (w_chan_led[k])
    );
  end

  assign led = w_chan_led & {NUM_CH{r_en}};

  always_comb begin
    w_rdata = 8'h00;
    if (addr == ADDR_CTRL) begin
      w_rdata = {7'b0000000, r_en};
    end else if (addr == ADDR_STATUS) begin
      w_rdata[NUM_CH-1:0] = led;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      w_rdata = w_rdata | w_ch_rdata[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= 8'h00;
    end else begin
      r_dout <= rd_en ? w_rdata : 8'h00;
    end
  end

  assign data_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_led_bank.sv
`default_nettype none
// tb_led_bank: directed and randomized checks of led_bank (NUM_CH=4, PRESCALE_W=4)
// against a reference model that derives led values from tick arithmetic.
module tb_led_bank;

  localparam int NUM_CH     = 4;
  localparam int PRESCALE_W = 4;
  localparam int TICK       = 1 << PRESCALE_W;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic              rd_en   = 1'b0;
  logic              wr_en   = 1'b0;
  logic [7:0]        addr    = 8'h00;
  logic [7:0]        data_in = 8'h00;
  logic [7:0]        data_out;
  logic [NUM_CH-1:0] led;

  int n_tests = 0;
  int n_fail  = 0;

  led_bank #(.NUM_CH(NUM_CH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .led      (led)
  );

  always #5 clk = ~clk;

  // Model: m_c counts cycles since the prescaler last started from zero;
  // m_w[k] is the cycle of the channel's last reprogramming (-1 = at start).
  bit         m_en;
  int         m_c;
  logic [7:0] m_per  [NUM_CH];
  logic [1:0] m_mode [NUM_CH];
  logic [7:0] m_duty [NUM_CH];
  int         m_w    [NUM_CH];
  logic [7:0] m_dout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_en   = 1'b1;
    m_c    = 0;
    m_dout = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      m_per[k]  = 8'h5D;
      m_mode[k] = 2'b10;
      m_duty[k] = 8'h80;
      m_w[k]    = -1;
    end
  endfunction

  function automatic void model_led(output logic [NUM_CH-1:0] e, output logic [NUM_CH-1:0] mask);
    logic [1:0] md;
    int         n;
    int         p;
    for (int k = 0; k < NUM_CH; k++) begin
      e[k]    = 1'b0;
      mask[k] = 1'b1;
      md      = m_mode[k];
`ifndef LED_BANK_PWM_EN
      if (md == 2'b11) md = 2'b10;
`endif
      if (m_en) begin
        case (md)
          2'b01: e[k] = (m_c > m_w[k] + 1);
          2'b10: begin
            p    = int'(m_per[k]);
            n    = m_c / TICK - (m_w[k] + 1) / TICK;
            e[k] = ((n / (p + 1)) % 2) == 1;
          end
          2'b11: mask[k] = 1'b0;
          default: e[k] = 1'b0;
        endcase
      end
    end
  endfunction

  function automatic logic [7:0] reg_read(input logic [7:0] a, input logic [NUM_CH-1:0] cur);
    int k;
    if (a == 8'h00) return {7'd0, m_en};
    if (a == 8'h01) return 8'(cur);
    if (a < 8'h04) return 8'h00;
    k = int'(a >> 2) - 1;
    if (k >= NUM_CH) return 8'h00;
    case (a[1:0])
      2'd0: return m_per[k];
      2'd1: return {6'd0, m_mode[k]};
`ifdef LED_BANK_PWM_EN
      2'd2: return m_duty[k];
`endif
      default: return 8'h00;
    endcase
  endfunction

  // Check the current cycle, advance the model by the inputs presented now, step a clock.
  task automatic cyc();
    logic [NUM_CH-1:0] e;
    logic [NUM_CH-1:0] mask;
    bit                new_en;
    int                k;
    model_led(e, mask);
    check_eq("led", led & mask, e & mask);
    check_eq("data_out", data_out, m_dout);
    m_dout = rd_en ? reg_read(addr, e) : 8'h00;
    new_en = m_en;
    if (wr_en) begin
      if (addr == 8'h00) begin
        new_en = data_in[0];
      end else if (addr >= 8'h04) begin
        k = int'(addr >> 2) - 1;
        if (k < NUM_CH) begin
          case (addr[1:0])
            2'd0: begin m_per[k]  = data_in;      if (m_en) m_w[k] = m_c; end
            2'd1: begin m_mode[k] = data_in[1:0]; if (m_en) m_w[k] = m_c; end
            2'd2: m_duty[k] = data_in;
            default: ;
          endcase
        end
      end
    end
    if (m_en) m_c++;
    if (new_en && !m_en) begin
      m_c = 0;
      for (int j = 0; j < NUM_CH; j++) m_w[j] = -1;
    end
    m_en = new_en;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1; rd_en = 1'b0;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    addr = a; rd_en = 1'b1; wr_en = 1'b0;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; rd_en = 1'b1; wr_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("rst_led", led, 0);
    check_eq("rst_dout", data_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic count_toggles(input int bit_idx, input int n, output int tog);
    logic prev;
    tog  = 0;
    prev = led[bit_idx];
    repeat (n) begin
      idle(1);
      if (led[bit_idx] != prev) tog++;
      prev = led[bit_idx];
    end
  endtask

  initial begin
    int         tog;
    int         hi;
    int         r;
    logic [7:0] a;
    logic [7:0] d;

    #2;
    do_reset();

    idle(1503);
    check_eq("pre_first_edge", led, 0);
    idle(1);
    check_eq("first_edge", led, {NUM_CH{1'b1}});
    rd(8'h04);
    check_eq("rd_period_rst", data_out, 8'h5D);

    do_reset();
    idle(1503);
    check_eq("restart_pre_edge", led, 0);
    idle(1);
    check_eq("restart_edge", led, {NUM_CH{1'b1}});
    idle(1504);
    check_eq("second_edge", led, 0);

    rdwr(8'h04, 8'h22);
    check_eq("rdwr_same", data_out, 8'h5D);
    rd(8'h04);
    check_eq("rd_after_wr", data_out, 8'h22);
    rd(8'h20);
    check_eq("rd_unmapped", data_out, 0);

    wr(8'h04, 8'h00);
    idle(2);
    count_toggles(0, 160, tog);
    check_eq("ch0_toggles", tog, 10);

    wr(8'h09, 8'h01);
    wr(8'h0D, 8'h00);
    idle(3);
    check_eq("ch1_on", led[1], 1'b1);
    check_eq("ch2_off", led[2], 1'b0);
    rd(8'h01);
    idle(1);

    idle(37);
    wr(8'h00, 8'h00);
    check_eq("dis_led", led, 0);
    idle(50);
    check_eq("dis_hold", led, 0);
    wr(8'h00, 8'hFF);
    idle(1503);
    check_eq("en_pre_edge", led[3], 1'b0);
    idle(1);
    check_eq("en_edge", led[3], 1'b1);
    rd(8'h00);
    check_eq("ctrl_rd", data_out, 8'h01);

`ifdef LED_BANK_PWM_EN
    wr(8'h06, 8'h40);
    wr(8'h05, 8'h03);
    idle(2);
    hi = 0;
    repeat (256) begin
      if (led[0]) hi++;
      idle(1);
    end
    check_eq("pwm_high_count", hi, 64);
    rd(8'h06);
    check_eq("rd_duty", data_out, 8'h40);
    wr(8'h05, 8'h02);
`else
    hi = 0;
    wr(8'h05, 8'h03);
    idle(2);
    count_toggles(0, 160, tog);
    check_eq("mode3_blink_toggles", tog, 10);
    rd(8'h06);
    check_eq("rd_duty_unmapped", data_out, 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 9))
        0:       a = 8'h20;
        1:       a = 8'hFF;
        default: a = 8'($urandom_range(0, 23));
      endcase
      d = 8'($urandom_range(0, 255));
      if (a >= 8'h04 && a[1:0] == 2'd0) d = 8'($urandom_range(0, 3));
`ifdef LED_BANK_PWM_EN
      if (a >= 8'h04 && a[1:0] == 2'd1 && d[1:0] == 2'b11) d[0] = 1'b0;
`endif
      addr    = a;
      data_in = d;
      rd_en   = (r < 25) || (r >= 97);
      wr_en   = (r >= 90);
      cyc();
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/led_bank.md
LED_BANK -- requirements
Module: led_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of LED channels; legal range 1..8.
REQ-002 Parameter PRESCALE_W, default 16: prescaler width; one tick every 2^PRESCALE_W clk cycles.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port rd_en, input, 1: register read strobe.
REQ-006 Port wr_en, input, 1: register write strobe.
REQ-007 Port addr, input, 8: register address.
REQ-008 Port data_in, input, 8: write data.
REQ-009 Port data_out, output, 8: registered read data.
REQ-010 Port led, output, NUM_CH: LED drive, one bit per channel.

Function
REQ-011 The register map SHALL be as follows.
- 0x00 CTRL: bit0 global enable, bits 7:1 read as 0.
- 0x01 STATUS: read-only current led value, zero-extended.
- 0x04+4k: PERIOD of channel k.
- 0x05+4k: MODE[1:0] of channel k.
- 0x06+4k: DUTY of channel k.
REQ-012 Reads SHALL return data on data_out one cycle after rd_en; data_out SHALL be 0 in any cycle following rd_en=0.
REQ-013 Unmapped or read-only addresses SHALL read 0 and ignore writes; writes SHALL take effect one cycle after wr_en.
REQ-014 When rd_en and wr_en target the same address in one cycle, the read SHALL return the pre-write value.
REQ-015 A shared prescaler SHALL count 0..2^PRESCALE_W-1 and pulse tick for one cycle on wrap.
REQ-016 MODE encodings SHALL be: 00 off (led=0), 01 on (led=1), 10 blink, 11 PWM.
REQ-017 In blink mode, each channel's 8-bit counter SHALL increment on tick; on a tick with counter>=PERIOD, led SHALL toggle and the counter SHALL clear, giving a half-period of (PERIOD+1) ticks.
REQ-018 PERIOD=0 SHALL toggle the channel on every tick.
REQ-019 A write to a channel's PERIOD or MODE SHALL clear that channel's counter and drive its led to 0 on the following cycle.
REQ-020 In PWM mode, led SHALL be 1 while a shared free-running 8-bit pwm counter (incrementing every clk) is less than DUTY: DUTY=0 gives always 0; DUTY=0xFF gives 255/256 high.
REQ-021 CTRL.enable=0 SHALL force all led to 0 and hold the prescaler, channel counters and pwm counter at 0; registers SHALL remain accessible.
REQ-022 Addresses for channels k>=NUM_CH SHALL behave as unmapped.

Reset
REQ-023 On reset_n low, the block SHALL immediately set: led=0, data_out=0, all counters=0, CTRL=0x01, every PERIOD=0x5D, every MODE=10, every DUTY=0x80.
REQ-024 Reset asserted mid-blink SHALL abort the current period; after release, the first toggle SHALL occur (PERIOD+1) ticks later.

Configuration
REQ-025 Macro LED_BANK_PWM_EN defined: PWM mode, the DUTY registers and the pwm counter SHALL be present.
REQ-026 Macro LED_BANK_PWM_EN undefined: MODE=11 SHALL behave as blink, DUTY addresses SHALL be unmapped, and no pwm counter SHALL be synthesised.

Structure
REQ-027 Package led_bank_pkg SHALL hold the mode enum typedef, register address constants and reset-value constants.
REQ-028 Per-channel counter, mode and led logic SHALL be a sub-module led_bank_chan, instantiated NUM_CH times by generate; the prescaler, pwm counter and register decode SHALL stay in led_bank.

Verification (PRESCALE_W=4, NUM_CH=4)
REQ-029 Reset release, no accesses -> all led toggle together, first edge at cycle 16*94, then every 1504 cycles; reading 0x04 returns 0x5D.
REQ-030 Write 0x04=0x00 -> led[0] toggles every 16 cycles; other channels are unaffected.
REQ-031 Write 0x09=0x01 then 0x0D=0x00 -> led[1]=1 and led[2]=0 constantly; reading 0x01 reflects current led.
REQ-032 Write 0x00=0x00 mid-period -> led=0 within one cycle and stays there; write 0x00=0x01 -> first toggle 1504 cycles later.
REQ-033 With LED_BANK_PWM_EN: write 0x06=0x40 and 0x05=0x03 -> led[0] high for 64 of every 256 cycles. Without it: led[0] blinks and reading 0x06 returns 0.
REQ-034 Same-cycle rd_en and wr_en to 0x04 with data 0x22 -> data_out=0x5D; a subsequent read returns 0x22; reading 0x20 returns 0.
